input_debouncer: RTL and testbench

Front-end conditioning stage that sits between the board switches and button and the arithmetic/display datapath. It synchronises and debounces the 8 operand switches and one capture button. It presents clean 4-bit operands A (sw[3:0]) and B (sw[7:4]) to the math and decoder stages, plus single-cycle event strobes. It runs on the 100 MHz board clock, not the divided display clock.

---
 rtl/input_debouncer_if.sv | 31 +++
 rtl/input_debouncer.sv | 85 ++++++++
 tb/tb_input_debouncer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Switch/button bundle for input_debouncer: raw levels in,
// clean levels, event strobes and operand nibbles out.
interface input_debouncer_if;
    logic [7:0] sw;
    logic       btn;
    logic [7:0] sw_db;
    logic       sw_changed;
    logic       btn_pulse;
    logic [3:0] operand_a;
    logic [3:0] operand_b;

    modport master (
        output sw,
        output btn,
        input  sw_db,
        input  sw_changed,
        input  btn_pulse,
        input  operand_a,
        input  operand_b
    );

    modport slave (
        input  sw,
        input  btn,
        output sw_db,
        output sw_changed,
        output btn_pulse,
        output operand_a,
        output operand_b
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchronise and debounce 8 switches + 1 button on the board clock.
// Define OPERAND_HOLD_EN to latch operands on a button press.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic         clock,
    input logic         reset,
    input_debouncer_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [8:0]    s1;
    logic [8:0]    s2;
    logic [8:0]    stable;
    logic [8:0]    stable_nxt;
    logic [CW-1:0] cnt     [9];
    logic [CW-1:0] cnt_nxt [9];
    logic          btn_q;
    logic          sw_changed;
    logic          btn_pulse;

    // Any cycle where s2 agrees with the accepted level restarts the count.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            stable_nxt[i] = stable[i];
            cnt_nxt[i]    = '0;
            if (s2[i] != stable[i]) begin
                if (cnt[i] == LAST) begin
                    stable_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            stable     <= '0;
            btn_q      <= 1'b0;
            sw_changed <= 1'b0;
            btn_pulse  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= {bus.btn, bus.sw};
            s2         <= s1;
            stable     <= stable_nxt;
            cnt        <= cnt_nxt;
            sw_changed <= (stable_nxt[7:0] != stable[7:0]);
            btn_q      <= stable[8];
            btn_pulse  <= stable[8] & ~btn_q;
        end
    end

    assign bus.sw_db      = stable[7:0];
    assign bus.sw_changed = sw_changed;
    assign bus.btn_pulse  = btn_pulse;

`ifdef OPERAND_HOLD_EN
    logic [3:0] op_a;
    logic [3:0] op_b;

    // Captures the pre-edge sw_db even if it changes on this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_a <= '0;
            op_b <= '0;
        end else if (btn_pulse) begin
            op_a <= stable[3:0];
            op_b <= stable[7:4];
        end
    end

    assign bus.operand_a = op_a;
    assign bus.operand_b = op_b;
`else
    assign bus.operand_a = stable[3:0];
    assign bus.operand_b = stable[7:4];
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// Random + directed bench for input_debouncer with DEBOUNCE_CYCLES=4,
// checked every cycle against a run-length reference model.
module tb_input_debouncer;
    localparam int DB = 4;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   n_chg;
    int   n_pls;
    int   edges;
    bit   chk_on;

    input_debouncer_if bus ();

    input_debouncer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: two-sample delay line, then a level is accepted once the
    // delayed input has disagreed with it for DB consecutive samples.
    logic [8:0] md1, md2, mst;
    int         mrun [9];
    logic       mchg, mpulse, mrose;
    logic [3:0] mopa, mopb;

    always @(posedge clock) begin
        logic [8:0] old;
        logic       p;
        if (reset) begin
            md1 = '0; md2 = '0; mst = '0;
            mchg = 0; mpulse = 0; mrose = 0;
            mopa = '0; mopb = '0;
            for (int i = 0; i < 9; i++) mrun[i] = 0;
        end else begin
            old = mst;
            p   = mpulse;
            for (int i = 0; i < 9; i++) begin
                if (md2[i] !== old[i]) begin
                    mrun[i] = mrun[i] + 1;
                    if (mrun[i] >= DB) begin
                        mst[i]  = md2[i];
                        mrun[i] = 0;
                    end
                end else begin
                    mrun[i] = 0;
                end
            end
            mchg   = (mst[7:0] != old[7:0]);
            mpulse = mrose;
            mrose  = mst[8] & ~old[8];
            if (p) begin
                mopa = old[3:0];
                mopb = old[7:4];
            end
            md2 = md1;
            md1 = {bus.btn, bus.sw};
        end
    end

    function automatic logic [7:0] exp_ops();
`ifdef OPERAND_HOLD_EN
        return {mopb, mopa};
`else
        return mst[7:0];
`endif
    endfunction

    always @(negedge clock) begin
        if (chk_on) begin
            check("cycle",
                  {13'd0, bus.sw_db, bus.sw_changed, bus.btn_pulse,
                   bus.operand_b, bus.operand_a},
                  {13'd0, mst[7:0], mchg, mpulse, exp_ops()});
        end
    end

    always @(posedge clock) begin
        if (chk_on && !reset) begin
            if (bus.sw_changed) n_chg++;
            if (bus.btn_pulse) n_pls++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_db(input logic [7:0] target,
                           input int limit,
                           output int e);
        e = 0;
        while (bus.sw_db !== target && e < limit) begin
            @(negedge clock);
            e++;
        end
    endtask

    task automatic clr_counts();
        n_chg = 0;
        n_pls = 0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; chk_on = 0;
        clr_counts();
        reset = 1'b1; bus.sw = 8'hFF; bus.btn = 1'b1;

        // Reset with switches and button held high
        @(posedge clock);
        chk_on = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_zero",
                  {bus.sw_db, bus.sw_changed, bus.btn_pulse,
                   bus.operand_b, bus.operand_a}, '0);
        end
        reset = 1'b0;
        clr_counts();
        wait_db(8'hFF, 20, edges);
        check("rst_lat", edges, 6);
        tick(4);
        check("rst_chg", n_chg, 1);
        check("rst_pls", n_pls, 1);

        // Clean change 00 -> 3A
        bus.sw = 8'h00; bus.btn = 1'b0;
        tick(12);
        clr_counts();
        bus.sw = 8'h3A;
        tick(5);
        check("clean_early", bus.sw_db, 8'h00);
        tick(1);
        check("clean_db", bus.sw_db, 8'h3A);
        check("clean_chg", bus.sw_changed, 1);
`ifndef OPERAND_HOLD_EN
        check("clean_opa", bus.operand_a, 4'hA);
        check("clean_opb", bus.operand_b, 4'h3);
`endif
        tick(1);
        check("clean_chg_off", bus.sw_changed, 0);
        tick(2);
        check("clean_nchg", n_chg, 1);

        // Bounce on sw[0], each level held 3 cycles
        clr_counts();
        for (int k = 0; k < 4; k++) begin
            bus.sw[0] = (k % 2 == 0);
            tick(3);
            check("bounce_hold", bus.sw_db[0], 0);
        end
        bus.sw[0] = 1'b1;
        wait_db(8'h3B, 20, edges);
        check("bounce_lat", edges, 6);
        tick(2);
        check("bounce_nchg", n_chg, 1);

        // Button: long press, release, 2-cycle glitch
        clr_counts();
        bus.btn = 1'b1; tick(20);
        bus.btn = 1'b0; tick(20);
        bus.btn = 1'b1; tick(2);
        bus.btn = 1'b0; tick(12);
        check("btn_npls", n_pls, 1);

        // Reset two cycles into a count
        bus.sw = 8'h00;
        tick(12);
        bus.sw = 8'h01;
        tick(4);
        reset = 1'b1;
        tick(2);
        check("midrst_db", bus.sw_db, 8'h00);
        reset = 1'b0;
        tick(5);
        check("midrst_early", bus.sw_db, 8'h00);
        tick(1);
        check("midrst_db2", bus.sw_db, 8'h01);

`ifdef OPERAND_HOLD_EN
        // Operands latch only on a button press
        bus.sw = 8'h5C;
        tick(10);
        check("hold_db", bus.sw_db, 8'h5C);
        check("hold_ops0", {bus.operand_b, bus.operand_a}, 8'h00);
        bus.btn = 1'b1;
        edges = 0;
        while (bus.btn_pulse !== 1'b1 && edges < 20) begin
            @(negedge clock);
            edges++;
        end
        check("hold_pls_to", edges < 20, 1);
        check("hold_ops_pls", {bus.operand_b, bus.operand_a}, 8'h00);
        tick(1);
        check("hold_ops", {bus.operand_b, bus.operand_a}, 8'h5C);
        bus.sw = 8'h11; bus.btn = 1'b0;
        tick(12);
        check("hold_db2", bus.sw_db, 8'h11);
        check("hold_keep", {bus.operand_b, bus.operand_a}, 8'h5C);
`endif

        // Random levels with random hold times and occasional resets
        for (int it = 0; it < 900; it++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                tick($urandom_range(1, 3));
                reset = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.sw = 8'($urandom);
            end else begin
                bus.sw[$urandom_range(0, 7)] ^= 1'b1;
            end
            bus.btn = 1'($urandom);
            tick($urandom_range(1, 9));
        end

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
